ram_responder: RTL
==================

# ram_responder

Memory-side responder for the pipeline's device memory port: the target that the instruction-fetch stage's request interface (`device_1_mem_*`) talks to. It accepts single-word reads, single-word writes and fixed-length read bursts, serves them from an internal synchronous RAM, and returns data with a per-word `do_ack` strobe after a configurable latency. It sits between the pipeline top and the on-chip instruction/data RAM, replacing the testbench memory model.

## Interface
- `ADDR_W`, 10: word-address width; RAM depth is 2^ADDR_W 32-bit words.
- `READ_LAT`, 2: cycles from request acceptance to first read `do_ack`; legal range 1..4.
- `BURST_LEN`, 4: words returned per read burst; legal range 2..16.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_en`  in  1  request valid from the initiator.
- `mem_we`  in  1  1 = write, 0 = read; tied 0 by read-only initiators.
- `burst_en`  in  1  read burst request; ignored when `mem_we`=1.
- `mem_addr`  in  32  byte address; word index = `mem_addr[ADDR_W+1:2]`.
- `mem_di`  in  32  write data.
- `mem_do`  out  32  read data; valid only in cycles with `do_ack`=1.
- `do_ack`  out  1  one-cycle strobe per completed word (read or write).
- `busy`  out  1  1 while a request is in progress (not IDLE).
- `err`  out  1  error strobe, coincident with `do_ack`; present only with the bounds-check option (see Configuration).

## Operation
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_ACK, HOLD.
- IDLE: when `mem_en`=1, latch `mem_addr`, `mem_we`, `burst_en` and `mem_di`. Go to WR_ACK if `mem_we`=1; otherwise go to RD_WAIT, loading the latency counter with READ_LAT-1.
- WR_ACK: write the RAM word, pulse `do_ack`, go to HOLD.
- RD_WAIT: decrement the counter. At 0, pulse `do_ack` with the first word. If burst, go to RD_BURST with the beat count at 1; otherwise go to HOLD.
- RD_BURST: one word per cycle with `do_ack`=1, word index +1 per beat. The index wraps modulo 2^ADDR_W. After beat BURST_LEN go to HOLD.
- HOLD: one cycle with `mem_en` ignored, then return to IDLE. The initiator drops `mem_en` in the cycle after its final `do_ack`, so a held `mem_en` never re-triggers a request.
- Input stability: `mem_addr`, `mem_di` and the control bits are sampled only in IDLE; later changes are ignored.
- `busy` = (state != IDLE).
- Reset: state IDLE, `do_ack`=0, `mem_do`=0, `err`=0, `busy`=0, counters 0. RAM contents are not cleared.
- Reset mid-transaction aborts the transaction: no further acks, and a pending write is not committed.

## Timing
- Request accepted at edge T (IDLE, `mem_en`=1).
- Single read: `do_ack` high in cycle T+READ_LAT.
- Read burst: `do_ack` high in cycles T+READ_LAT through T+READ_LAT+BURST_LEN-1, contiguous.
- Write: `do_ack` high in cycle T+1; the RAM is updated at that same edge.
- Earliest next acceptance is 2 cycles after the last `do_ack` (the HOLD cycle, then IDLE).
- Write-then-read to the same address returns the new data.
- `mem_do` is registered and holds its last value when `do_ack`=0.

## Configuration
- Macro: `RAM_RESP_BOUNDS_CHECK_EN`.
- Defined: a request is flagged in error if `mem_addr[1:0]` != 0, or if any bit of `mem_addr[31:ADDR_W+2]` is set.
  - Flagged read: returns 32'h0 on every beat, with `err`=1 on every `do_ack`.
  - Flagged write: suppressed; `err`=1 with its `do_ack`.
  - Burst wrap beyond the top word is flagged per beat.
- Undefined: the `err` port is absent, the low two address bits and the high address bits are ignored (aliasing), and bursts wrap silently.

## Structure
- Package `ram_resp_pkg`: state enum `ram_resp_state_t`, constant `RAM_RESP_ERR_DATA` (32'h0), and the legal limits for READ_LAT and BURST_LEN.
- Sub-module `ram_resp_mem`: single-port synchronous RAM with 32-bit data and a 1-cycle registered read. The latency counter absorbs its delay, so READ_LAT ≥ 1.

## Test plan
- Reset with `mem_en`=1 held: every output stays 0 for the whole reset period. After release, the request is accepted on the first edge.
- Write 32'hCAFE0001 to addr 0x10, then read 0x10: write `do_ack` at T+1; read returns 32'hCAFE0001 at T'+2 (READ_LAT=2).
- Burst read at 0x0 after writing words 0..3 = 1,2,3,4: four contiguous acks returning 1,2,3,4. `mem_en` held high afterward causes no re-trigger during HOLD.
- Burst starting at the top word (index 1023, ADDR_W=10): data from indices 1023, 0, 1, 2.
- Reset asserted in RD_WAIT and again in WR_ACK: no `do_ack`; the aborted write leaves the old RAM value.
- With `RAM_RESP_BOUNDS_CHECK_EN`:
  - Read of 0x2 (misaligned): `mem_do`=0, `err`=1.
  - Write to 0x1000 (beyond RAM): `err`=1, RAM unchanged.
  - Without the macro, a read of 0x1000 returns the word at 0x0.

Source files
------------

// File: rtl/ram_resp_pkg.sv
// Shared types and limits for the ram_responder memory-side responder.
package ram_resp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_ACK   = 3'd3,
    HOLD     = 3'd4
  } ram_resp_state_t;

  localparam logic [31:0] RAM_RESP_ERR_DATA = 32'h0000_0000;

  localparam int READ_LAT_MIN  = 1;
  localparam int READ_LAT_MAX  = 4;
  localparam int BURST_LEN_MIN = 2;
  localparam int BURST_LEN_MAX = 16;

  localparam int LAT_CNT_W  = 3;
  localparam int BEAT_CNT_W = 5;

  // Misaligned, or addressing beyond the 2^addr_w-word RAM.
  function automatic logic addr_flagged(input logic [31:0] addr, input int addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/ram_resp_mem.sv
// Single-port synchronous RAM, 32-bit words, one-cycle registered read.
module ram_resp_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1 << ADDR_W) - 1];
  logic [31:0] rdata_q;

  // Read returns the pre-write contents when reading the word being written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Device-memory responder: single reads/writes and fixed-length read bursts.
// Optional bounds checking and err output enabled by RAM_RESP_BOUNDS_CHECK_EN.
module ram_responder
  import ram_resp_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 2,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic        burst_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_di,
  output logic [31:0] mem_do,
  output logic        do_ack,
  output logic        busy
`ifdef RAM_RESP_BOUNDS_CHECK_EN
  , output logic      err
`endif
);

  ram_resp_state_t       state_q;
  logic [ADDR_W-1:0]     idx_q;
  logic                  burst_q;
  logic [31:0]           di_q;
  logic [LAT_CNT_W-1:0]  lat_q;
  logic [BEAT_CNT_W-1:0] beat_q;
  logic                  do_ack_q;
  logic [31:0]           mem_do_q;

  logic [ADDR_W-1:0]     mem_idx_s;
  logic [ADDR_W-1:0]     idx_inc_s;
  logic [ADDR_W-1:0]     ram_addr_s;
  logic                  ram_we_s;
  logic [31:0]           ram_rdata_s;
  logic [31:0]           beat_data_s;

`ifdef RAM_RESP_BOUNDS_CHECK_EN
  logic flag_q;
  logic wrap_q;
  logic err_q;
  logic beat_err_s;
  logic idx_top_s;
`else
  logic addr_unused_s;
  assign addr_unused_s = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`endif

  assign mem_idx_s = mem_addr[ADDR_W+1:2];
  assign idx_inc_s = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // RAM address runs one word ahead of idx_q once the first beat is due.
  always_comb begin
    ram_addr_s = idx_q;
    case (state_q)
      IDLE:     ram_addr_s = mem_idx_s;
      RD_WAIT: begin
        if (lat_q == '0) begin
          ram_addr_s = idx_inc_s;
        end else begin
          ram_addr_s = idx_q;
        end
      end
      RD_BURST: ram_addr_s = idx_inc_s;
      default:  ram_addr_s = idx_q;
    endcase
  end

  // Write commits at the WR_ACK edge unless reset aborts it.
  always_comb begin
    ram_we_s = 1'b0;
`ifdef RAM_RESP_BOUNDS_CHECK_EN
    if ((state_q == WR_ACK) && !reset && !flag_q) begin
`else
    if ((state_q == WR_ACK) && !reset) begin
`endif
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Data presented on a read beat.
  always_comb begin
`ifdef RAM_RESP_BOUNDS_CHECK_EN
    beat_err_s = flag_q | wrap_q;
    idx_top_s  = (idx_q == {ADDR_W{1'b1}});
    if (beat_err_s) begin
      beat_data_s = RAM_RESP_ERR_DATA;
    end else begin
      beat_data_s = ram_rdata_s;
    end
`else
    beat_data_s = ram_rdata_s;
`endif
  end

  ram_resp_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (di_q),
    .rdata_o (ram_rdata_s)
  );

  // Request FSM with registered ack, data and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      burst_q  <= 1'b0;
      di_q     <= 32'h0000_0000;
      lat_q    <= '0;
      beat_q   <= '0;
      do_ack_q <= 1'b0;
      mem_do_q <= 32'h0000_0000;
`ifdef RAM_RESP_BOUNDS_CHECK_EN
      flag_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      do_ack_q <= 1'b0;
`ifdef RAM_RESP_BOUNDS_CHECK_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (mem_en) begin
            idx_q   <= mem_idx_s;
            burst_q <= burst_en & ~mem_we;
            di_q    <= mem_di;
            beat_q  <= '0;
`ifdef RAM_RESP_BOUNDS_CHECK_EN
            flag_q  <= addr_flagged(mem_addr, ADDR_W);
            wrap_q  <= 1'b0;
`endif
            if (mem_we) begin
              state_q <= WR_ACK;
            end else begin
              state_q <= RD_WAIT;
              lat_q   <= LAT_CNT_W'(READ_LAT - 1);
            end
          end
        end
        WR_ACK: begin
          do_ack_q <= 1'b1;
`ifdef RAM_RESP_BOUNDS_CHECK_EN
          err_q    <= flag_q;
`endif
          state_q  <= HOLD;
        end
        RD_WAIT: begin
          if (lat_q == '0) begin
            do_ack_q <= 1'b1;
            mem_do_q <= beat_data_s;
            idx_q    <= idx_inc_s;
`ifdef RAM_RESP_BOUNDS_CHECK_EN
            err_q    <= beat_err_s;
            wrap_q   <= wrap_q | idx_top_s;
`endif
            if (burst_q) begin
              beat_q  <= BEAT_CNT_W'(1);
              state_q <= RD_BURST;
            end else begin
              state_q <= HOLD;
            end
          end else begin
            lat_q <= lat_q - LAT_CNT_W'(1);
          end
        end
        RD_BURST: begin
          do_ack_q <= 1'b1;
          mem_do_q <= beat_data_s;
          idx_q    <= idx_inc_s;
          beat_q   <= beat_q + BEAT_CNT_W'(1);
`ifdef RAM_RESP_BOUNDS_CHECK_EN
          err_q    <= beat_err_s;
          wrap_q   <= wrap_q | idx_top_s;
`endif
          if (beat_q == BEAT_CNT_W'(BURST_LEN - 1)) begin
            state_q <= HOLD;
          end
        end
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_do = mem_do_q;
  assign do_ack = do_ack_q;
  assign busy   = (state_q != IDLE);
`ifdef RAM_RESP_BOUNDS_CHECK_EN
  assign err    = err_q;
`endif

endmodule
